// File: rtl/fir_datapath.sv
// 8-tap signed FIR datapath: shiftable sample delay line, writable coefficient bank,
// and a combinational multiply-accumulate producing a sign-extended 32-bit result.
module fir_datapath (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_shift_enable,
   input  logic        i_coeff_write_en,
   input  logic [2:0]  i_coeff_addr,
   input  logic [7:0]  i_coeff_data,
   input  logic [7:0]  i_data,
   output logic [31:0] o_data
);

   localparam int unsigned NUM_TAPS = 8;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned COEFF_W  = 8;
   localparam int unsigned PROD_W   = 16;
   localparam int unsigned OUT_W    = 32;

   logic signed [DATA_W-1:0]  r_taps   [NUM_TAPS];
   logic signed [COEFF_W-1:0] r_coeffs [NUM_TAPS];
   logic signed [PROD_W-1:0]  w_prods  [NUM_TAPS];
   logic signed [OUT_W-1:0]   w_sum;

   // Reset port is asserted high despite its name; it clears every tap and coefficient.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            r_taps[k]   <= '0;
            r_coeffs[k] <= '0;
         end
      end else begin
         if (i_shift_enable) begin
            r_taps[0] <= signed'(i_data);
            for (int k = 1; k < NUM_TAPS; k++) begin
               r_taps[k] <= r_taps[k-1];
            end
         end
         if (i_coeff_write_en) begin
            r_coeffs[i_coeff_addr] <= signed'(i_coeff_data);
         end
      end
   end

   // Full-precision signed products, summed after sign extension to the output width.
   always_comb begin
      w_sum = '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
         w_prods[k] = PROD_W'(r_coeffs[k] * r_taps[k]);
         w_sum      = w_sum + OUT_W'(w_prods[k]);
      end
   end

   assign o_data = w_sum;

endmodule

// File: tb/tb_fir_datapath.sv
// Directed, table-driven bench for fir_datapath plus hand-written sequences for
// asynchronous reset behaviour.
module tb_fir_datapath;

   logic        clk;
   logic        rst_n;
   logic        i_shift_enable;
   logic        i_coeff_write_en;
   logic [2:0]  i_coeff_addr;
   logic [7:0]  i_coeff_data;
   logic [7:0]  i_data;
   logic [31:0] o_data;

   int n_checks;
   int n_fail;

   fir_datapath dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_shift_enable   (i_shift_enable),
      .i_coeff_write_en (i_coeff_write_en),
      .i_coeff_addr     (i_coeff_addr),
      .i_coeff_data     (i_coeff_data),
      .i_data           (i_data),
      .o_data           (o_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        rst;
      logic        shift;
      logic        we;
      logic [2:0]  addr;
      logic [7:0]  cdata;
      logic [7:0]  data;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string name, bit rst, bit sh, bit we, int addr, int cd, int d, int exp);
      vec_t v;
      v.name  = name;
      v.rst   = rst;
      v.shift = sh;
      v.we    = we;
      v.addr  = 3'(addr);
      v.cdata = 8'(cd);
      v.data  = 8'(d);
      v.exp   = 32'(exp);
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: o_data=%0d expected=%0d", name, $signed(act), $signed(exp));
      end
   endtask

   task automatic drive(bit rst, bit sh, bit we, int addr, int cd, int d);
      rst_n            = rst;
      i_shift_enable   = sh;
      i_coeff_write_en = we;
      i_coeff_addr     = 3'(addr);
      i_coeff_data     = 8'(cd);
      i_data           = 8'(d);
   endtask

   // Drive at falling edge, let one rising edge happen, sample just after it.
   task automatic step(bit rst, bit sh, bit we, int addr, int cd, int d);
      @(negedge clk);
      drive(rst, sh, we, addr, cd, d);
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
      #1;
      check("reset_state", o_data, 32'd0);

      // Impulse response
      vecs.push_back(mk("imp_rst",   1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("imp_h0",    0, 0, 1, 0, 8, 0, 0));
      vecs.push_back(mk("imp_h1",    0, 0, 1, 1, 4, 0, 0));
      vecs.push_back(mk("imp_h2",    0, 0, 1, 2, 2, 0, 0));
      vecs.push_back(mk("imp_h3",    0, 0, 1, 3, 1, 0, 0));
      vecs.push_back(mk("imp_s1",    0, 1, 0, 0, 0, 1, 8));
      vecs.push_back(mk("imp_s2",    0, 1, 0, 0, 0, 0, 4));
      vecs.push_back(mk("imp_s3",    0, 1, 0, 0, 0, 0, 2));
      vecs.push_back(mk("imp_s4",    0, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk("imp_s5",    0, 1, 0, 0, 0, 0, 0));
      // Ramp coefficients, hold, then flush
      vecs.push_back(mk("ramp_rst",  1, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 8; k++) vecs.push_back(mk("ramp_load", 0, 0, 1, k, k + 1, 0, 0));
      vecs.push_back(mk("ramp_10",   0, 1, 0, 0, 0, 10, 10));
      vecs.push_back(mk("ramp_20",   0, 1, 0, 0, 0, 20, 40));
      vecs.push_back(mk("ramp_30",   0, 1, 0, 0, 0, 30, 100));
      vecs.push_back(mk("ramp_40",   0, 1, 0, 0, 0, 40, 200));
      vecs.push_back(mk("ramp_50",   0, 1, 0, 0, 0, 50, 350));
      vecs.push_back(mk("hold_1",    0, 0, 0, 0, 0, 99, 350));
      vecs.push_back(mk("hold_2",    0, 0, 0, 0, 0, 99, 350));
      vecs.push_back(mk("hold_3",    0, 0, 0, 0, 0, 99, 350));
      vecs.push_back(mk("flush_1",   0, 1, 0, 0, 0, 0, 500));
      vecs.push_back(mk("flush_2",   0, 1, 0, 0, 0, 0, 650));
      vecs.push_back(mk("flush_3",   0, 1, 0, 0, 0, 0, 800));
      vecs.push_back(mk("flush_4",   0, 1, 0, 0, 0, 0, 860));
      vecs.push_back(mk("flush_5",   0, 1, 0, 0, 0, 0, 820));
      vecs.push_back(mk("flush_6",   0, 1, 0, 0, 0, 0, 670));
      vecs.push_back(mk("flush_7",   0, 1, 0, 0, 0, 0, 400));
      vecs.push_back(mk("flush_8",   0, 1, 0, 0, 0, 0, 0));
      // Signed extremes
      vecs.push_back(mk("sgn_rst",   1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("sgn_h0",    0, 0, 1, 0, -128, 0, 0));
      vecs.push_back(mk("sgn_mm",    0, 1, 0, 0, 0, -128, 16384));
      vecs.push_back(mk("sgn_pm",    0, 0, 1, 0, 127, 5, -16256));
      vecs.push_back(mk("sgn_hold",  0, 0, 0, 0, 0, 5, -16256));
      // Simultaneous write and shift
      vecs.push_back(mk("sim_rst",   1, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk("sim_ws1",   0, 1, 1, 0, 5, 3, 15));
      vecs.push_back(mk("sim_ws2",   0, 1, 1, 0, 7, 4, 28));
      vecs.push_back(mk("sim_h1",    0, 0, 1, 1, 2, 0, 34));
      // Writes and shifts ignored during reset
      vecs.push_back(mk("rst_ign",   1, 1, 1, 0, 5, 3, 0));
      vecs.push_back(mk("rst_ign_2", 0, 0, 0, 0, 0, 3, 0));

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].shift, vecs[i].we, int'(vecs[i].addr),
              int'(vecs[i].cdata), int'(vecs[i].data));
         check(vecs[i].name, o_data, vecs[i].exp);
      end

      // Mid-run asynchronous reset: clears within the cycle, no clock edge needed
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 1, 0);
      step(0, 0, 1, 1, 2, 0);
      step(0, 1, 0, 0, 0, 10);
      check("mid_pre_10", o_data, 32'd10);
      step(0, 1, 0, 0, 0, 20);
      check("mid_pre_20", o_data, 32'd40);
      #2;
      rst_n = 1'b1;
      #1;
      check("mid_async_clear", o_data, 32'd0);
      step(0, 1, 0, 0, 0, 30);
      check("mid_after_30", o_data, 32'd0);
      step(0, 1, 0, 0, 0, 40);
      check("mid_after_40", o_data, 32'd0);
      // Operation resumes on the first edge after release
      step(0, 1, 1, 0, 3, 9);
      check("mid_resume", o_data, 32'd27);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
